// File: rtl/matmul_result_drain.sv
// matmul_result_drain: streams the N x N result matrix out of the engine's result memory in row-major order
module matmul_result_drain #(
   parameter int MATRIX_DIM = 32,
   parameter int ACC_WIDTH  = 32,
   parameter int IDX_WIDTH  = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1,
   parameter int ADDR_WIDTH = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM * MATRIX_DIM) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ACC_WIDTH-1:0]  rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ACC_WIDTH-1:0]  m_data,
   output logic [IDX_WIDTH-1:0]  m_row,
   output logic [IDX_WIDTH-1:0]  m_col,
   output logic                  m_last
);
   localparam logic [ADDR_WIDTH:0]  TOTAL    = (ADDR_WIDTH + 1)'(MATRIX_DIM * MATRIX_DIM);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MATRIX_DIM - 1);
   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH:0]  issue_cnt;
   logic                 inflight;
   logic [1:0]           cnt;
   logic [ACC_WIDTH-1:0] head, tail;
   logic [IDX_WIDTH-1:0] row, col;
   logic                 push, pop, at_last, go;
   assign go       = state == IDLE && start;
   assign push     = inflight;
   assign pop      = m_valid && m_ready;
   assign at_last  = row == LAST_IDX && col == LAST_IDX;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign m_valid  = cnt != 2'd0;
   assign m_data   = head;
   assign m_row    = row;
   assign m_col    = col;
   assign m_last   = m_valid && at_last;
   assign rd_addr  = issue_cnt[ADDR_WIDTH-1:0];
   // A beat leaving this cycle frees a slot, which keeps one read per clock flowing with m_ready high
   assign rd_en    = state == DRAIN && issue_cnt < TOTAL &&
                     ({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   // next state: drain until the last beat is accepted, then one DONE cycle
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE)  ? (start ? DRAIN : IDLE) :
                  (state == DRAIN) ? ((pop && at_last) ? DONE : DRAIN) : IDLE;
   end
   // read issue, 2-entry output FIFO and row/col tag counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         inflight  <= 1'b0;
         cnt       <= 2'd0;
         head      <= '0;
         tail      <= '0;
         row       <= '0;
         col       <= '0;
      end else begin
         inflight  <= rd_en;
         issue_cnt <= go ? '0 : rd_en ? issue_cnt + (ADDR_WIDTH + 1)'(1) : issue_cnt;
         cnt       <= cnt + 2'(push) - 2'(pop);
         head      <= (pop && cnt == 2'd2) ? tail :
                      (push && (cnt == 2'd0 || (pop && cnt == 2'd1))) ? rd_data : head;
         tail      <= (push && (cnt == 2'd2 || (!pop && cnt == 2'd1))) ? rd_data : tail;
         col       <= go ? '0 : pop ? ((col == LAST_IDX) ? '0 : col + IDX_WIDTH'(1)) : col;
         row       <= go ? '0 : (pop && col == LAST_IDX) ? ((row == LAST_IDX) ? '0 : row + IDX_WIDTH'(1)) : row;
      end
   end
endmodule

// File: tb/tb_matmul_result_drain.sv
// tb_matmul_result_drain: randomized and directed checks of the result drain against a row-major reference
module tb_matmul_result_drain;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, m_ready = 1'b0;
   logic        busy, done, rd_en, m_valid, m_last;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data = '0, m_data;
   logic [1:0]  m_row, m_col;
   logic        start1 = 1'b0, ready1 = 1'b0;
   logic        busy1, done1, rd_en1, mv1, ml1;
   logic [0:0]  rd_addr1, mr1, mc1;
   logic [31:0] rd_data1 = '0, md1;
   logic [31:0] mem4 [16];
   logic [31:0] mem1 [1];
   int checks = 0, errors = 0;

   matmul_result_drain #(.MATRIX_DIM(4), .ACC_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_row(m_row), .m_col(m_col), .m_last(m_last));

   matmul_result_drain #(.MATRIX_DIM(1), .ACC_WIDTH(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .m_valid(mv1), .m_ready(ready1), .m_data(md1),
      .m_row(mr1), .m_col(mc1), .m_last(ml1));

   always #5 clk = ~clk;

   // result memories with one clock of read latency
   always @(posedge clk) begin
      if (rd_en)  rd_data  <= mem4[rd_addr];
      if (rd_en1) rd_data1 <= mem1[rd_addr1];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: ready low for 20 clk, 3: extra start mid-drain
   task automatic drain(input int mode, input int abort_at);
      logic [31:0] exp_d [$];
      int beat, issued, dn, first_v, last_cyc;
      logic hold, pl;
      logic [31:0] pd;
      logic [1:0] pr, pc;
      for (int k = 0; k < 16; k++) exp_d.push_back(mem4[k]);
      beat = 0; issued = 0; dn = 0; first_v = -1; last_cyc = -1; hold = 1'b0;
      pd = '0; pr = '0; pc = '0; pl = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      m_ready = (mode == 0 || mode == 3);
      #1;
      for (int cyc = 1; cyc < 400 && dn == 0; cyc++) begin
         @(posedge clk); #1;
         start = (mode == 3 && cyc == 8);
         m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2) ? (cyc > 20) : 1'b1;
         #1;
         if (cyc == 1) chk("rd_en_latency", 64'(rd_en), 64'd1);
         if (m_valid && first_v < 0) first_v = cyc;
         if (hold) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_beat", {m_data, m_row, m_col, m_last}, {pd, pr, pc, pl});
         end
         if (mode == 2 && cyc == 20) begin
            chk("stall_reads", 64'(issued), 64'd2);
            chk("stall_rd_en", 64'(rd_en), 64'd0);
            chk("stall_head", {m_valid, m_data, m_row, m_col}, {1'b1, exp_d[0], 2'd0, 2'd0});
         end
         if (rd_en) begin
            chk("rd_addr", 64'(rd_addr), 64'(issued));
            issued++;
         end
         if (m_valid && m_ready) begin
            chk("beat", {m_data, m_row, m_col, m_last},
                {exp_d[beat], 2'(beat / 4), 2'(beat % 4), beat == 15});
            beat++;
            last_cyc = cyc;
         end
         if (rd_en) chk("outstanding_le2", 64'(issued - beat <= 2), 64'd1);
         if (done) begin
            dn++;
            chk("done_latency", 64'(cyc - last_cyc), 64'd1);
         end
         hold = m_valid && !m_ready;
         pd = m_data; pr = m_row; pc = m_col; pl = m_last;
         if (abort_at > 0 && beat == abort_at) break;
      end
      if (abort_at > 0) begin
         chk("abort_beats", 64'(beat), 64'(abort_at));
         @(posedge clk); #1;
         rst_n = 1'b0;
         #1;
         chk("async_reset_outs", {busy, done, rd_en, rd_addr, m_valid, m_last, m_data, m_row, m_col}, 64'd0);
         @(posedge clk); #1;
         rst_n = 1'b1;
         return;
      end
      chk("beat_count", 64'(beat), 64'd16);
      chk("done_count", 64'(dn), 64'd1);
      if (mode == 0) begin
         chk("first_valid", 64'(first_v), 64'd3);
         chk("back_to_back", 64'(last_cyc), 64'(first_v + 15));
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("after_done", {busy, done}, 64'd0);
      if (mode == 3) begin
         repeat (5) @(posedge clk);
         #1;
         chk("no_requeue", {busy, m_valid}, 64'd0);
      end
   endtask

   initial begin
      int b1, dn1, acc1;
      for (int k = 0; k < 16; k++) mem4[k] = 32'(k + 100);
      mem1[0] = 32'hFFFF_FFFF;
      #1;
      chk("reset_outs", {busy, done, rd_en, rd_addr, m_valid, m_last, m_data, m_row, m_col}, 64'd0);
      chk("reset_outs1", {busy1, done1, rd_en1, mv1, ml1, md1}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drain(0, 0);
      drain(1, 0);
      drain(2, 0);
      drain(3, 0);
      drain(0, 0);
      drain(0, 7);
      drain(0, 0);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 16; k++) mem4[k] = $urandom;
         drain(1, 0);
      end
      b1 = 0; dn1 = 0; acc1 = -1;
      @(posedge clk); #1;
      start1 = 1'b1;
      ready1 = 1'b1;
      for (int cyc = 1; cyc < 20 && dn1 == 0; cyc++) begin
         @(posedge clk); #1;
         start1 = 1'b0;
         #1;
         if (mv1 && ready1) begin
            chk("n1_beat", {md1, mr1, mc1, ml1}, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1});
            b1++;
            acc1 = cyc;
         end
         if (done1) begin
            dn1++;
            chk("n1_done_latency", 64'(cyc - acc1), 64'd1);
         end
      end
      chk("n1_beats", 64'(b1), 64'd1);
      chk("n1_done", 64'(dn1), 64'd1);
      @(posedge clk); #1;
      chk("n1_idle", {busy1, done1, mv1}, 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
